// File: rtl/cmp_flag_unit.sv
// rtl/cmp_flag_unit.sv - comparator flag latch and branch condition evaluator
// Optional BR_STATS_EN adds saturating taken/not-taken decision counters.
module cmp_flag_unit #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_we,
  input  logic       eq_in,
  input  logic       lt_in,
  input  logic       gt_in,
  input  logic       cond_valid,
  input  logic [2:0] cond_code,
  output logic       cond_ready,
  output logic       br_valid,
  output logic       br_taken,
  input  logic       br_ready,
  output logic [2:0] flags_out,
  output logic       flag_err
`ifdef BR_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
`endif
);

  typedef enum logic [1:0] {
    NOFLAG = 2'd0,
    IDLE   = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic flag_onehot;
  logic flag_ok;
  logic cond_fire;
  logic cond_true;

  // Exactly one flag set: odd parity rules out 0 and 2 set, the AND rules out all 3.
  assign flag_onehot = (gt_in ^ lt_in ^ eq_in) & ~(gt_in & lt_in & eq_in);
  assign flag_ok     = flag_we & flag_onehot;
  assign cond_fire   = cond_valid & cond_ready;
  assign br_valid    = (state == RESP);

  always_comb begin
    cond_true = 1'b0;
    case (cond_code)
      3'd0: cond_true = flags_out[0];
      3'd1: cond_true = ~flags_out[0];
      3'd2: cond_true = flags_out[1];
      3'd3: cond_true = flags_out[2] | flags_out[0];
      3'd4: cond_true = flags_out[2];
      3'd5: cond_true = flags_out[1] | flags_out[0];
      3'd6: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Requests evaluate against registered flags only, so a same-cycle write stalls them.
  always_comb begin
    state_nxt  = state;
    cond_ready = 1'b0;
    case (state)
      NOFLAG: begin
        if (flag_ok) state_nxt = IDLE;
      end
      IDLE: begin
        cond_ready = ~flag_we;
        if (cond_fire) state_nxt = RESP;
      end
      RESP: begin
        if (br_ready) state_nxt = IDLE;
      end
      default: state_nxt = NOFLAG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NOFLAG;
      flags_out <= 3'b000;
      flag_err  <= 1'b0;
      br_taken  <= 1'b0;
    end else begin
      state    <= state_nxt;
      flag_err <= flag_we & ~flag_onehot;
      if (flag_ok) flags_out <= {gt_in, lt_in, eq_in};
      if (cond_fire) br_taken <= cond_true;
    end
  end

`ifdef BR_STATS_EN
  logic br_fire;
  assign br_fire = br_valid & br_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (br_fire) begin
      if (br_taken && !(&taken_cnt)) taken_cnt <= taken_cnt + CNT_W'(1);
      if (!br_taken && !(&ntaken_cnt)) ntaken_cnt <= ntaken_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cmp_flag_unit.sv
// tb/tb_cmp_flag_unit.sv - directed and randomized bench for cmp_flag_unit
module tb_cmp_flag_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flag_we = 1'b0;
  logic       eq_in = 1'b0;
  logic       lt_in = 1'b0;
  logic       gt_in = 1'b0;
  logic       cond_valid = 1'b0;
  logic [2:0] cond_code = 3'd0;
  logic       cond_ready;
  logic       br_valid;
  logic       br_taken;
  logic       br_ready = 1'b0;
  logic [2:0] flags_out;
  logic       flag_err;
`ifdef BR_STATS_EN
  logic [7:0] taken_cnt;
  logic [7:0] ntaken_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  cmp_flag_unit #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flag_we    (flag_we),
    .eq_in      (eq_in),
    .lt_in      (lt_in),
    .gt_in      (gt_in),
    .cond_valid (cond_valid),
    .cond_code  (cond_code),
    .cond_ready (cond_ready),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .br_ready   (br_ready),
    .flags_out  (flags_out),
    .flag_err   (flag_err)
`ifdef BR_STATS_EN
    ,
    .taken_cnt  (taken_cnt),
    .ntaken_cnt (ntaken_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: flags viewed as the sign of (a - b); conditions are relations on that sign.
  function automatic bit model_eval(input logic [2:0] code, input logic [2:0] f);
    int rel;
    rel = f[2] ? 1 : (f[1] ? -1 : 0);
    case (code)
      3'd0: return rel == 0;
      3'd1: return rel != 0;
      3'd2: return rel < 0;
      3'd3: return rel >= 0;
      3'd4: return rel > 0;
      3'd5: return rel <= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_flag(input logic [2:0] pat);
    flag_we = 1'b1;
    {gt_in, lt_in, eq_in} = pat;
    cycle();
    flag_we = 1'b0;
    {gt_in, lt_in, eq_in} = 3'b000;
  endtask

  task automatic request(input logic [2:0] code, input bit exp_taken, input string tag);
    int n;
    n = 0;
    cond_valid = 1'b1;
    cond_code  = code;
    #1;
    while (!cond_ready && n < 20) begin
      cycle();
      #1;
      n++;
    end
    check({tag, "_rdy"}, cond_ready, 1);
    cycle();
    cond_valid = 1'b0;
    check({tag, "_bv"}, br_valid, 1);
    check({tag, "_bt"}, br_taken, exp_taken);
    br_ready = 1'b1;
    cycle();
    br_ready = 1'b0;
    check({tag, "_drain"}, br_valid, 0);
  endtask

  logic [2:0] model_flags;
  logic [2:0] pat;
  logic [2:0] code;
  bit         exp_t;
  bit         tbl [6];

  initial begin
    tbl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // reset state
    cycle();
    cycle();
    check("rst_flags", flags_out, 0);
    check("rst_err", flag_err, 0);
    check("rst_bv", br_valid, 0);
    check("rst_bt", br_taken, 0);
    check("rst_crdy", cond_ready, 0);
    rst = 1'b0;

    // no flags yet: ALWAYS request stalls until a valid flag write
    cond_valid = 1'b1;
    cond_code  = 3'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("noflag_crdy", cond_ready, 0);
      cycle();
    end
    flag_we = 1'b1;
    eq_in   = 1'b1;
    #1;
    check("noflag_wr_crdy", cond_ready, 0);
    cycle();
    flag_we = 1'b0;
    eq_in   = 1'b0;
    check("t1_flags", flags_out, 3'b001);
    #1;
    check("t1_crdy", cond_ready, 1);
    cycle();
    cond_valid = 1'b0;
    check("t1_bv", br_valid, 1);
    check("t1_bt", br_taken, 1);
    br_ready = 1'b1;
    cycle();
    br_ready = 1'b0;
    check("t1_drain", br_valid, 0);

    // greater-than flags against the six relational codes
    do_flag(3'b100);
    check("t2_flags", flags_out, 3'b100);
    for (int i = 0; i < 6; i++) request(3'(i), tbl[i], $sformatf("t2_code%0d", i));

    // invalid flag write holds flags and pulses flag_err once
    do_flag(3'b010);
    check("t3_flags_pre", flags_out, 3'b010);
    check("t3_err_pre", flag_err, 0);
    do_flag(3'b011);
    check("t3_flags_hold", flags_out, 3'b010);
    check("t3_err", flag_err, 1);
    cycle();
    check("t3_err_clr", flag_err, 0);
    check("t3_flags_hold2", flags_out, 3'b010);

    // decision held in RESP while the flags change underneath
    do_flag(3'b100);
    cond_valid = 1'b1;
    cond_code  = 3'd4;
    #1;
    check("t4_crdy", cond_ready, 1);
    cycle();
    cond_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t4_bv_hold", br_valid, 1);
      check("t4_bt_hold", br_taken, 1);
      flag_we = (k == 1);
      lt_in   = (k == 1);
      cycle();
    end
    flag_we = 1'b0;
    lt_in   = 1'b0;
    check("t4_flags_upd", flags_out, 3'b010);
    check("t4_bt_after", br_taken, 1);
    br_ready = 1'b1;
    #1;
    check("t4_bv_last", br_valid, 1);
    cycle();
    br_ready = 1'b0;
    check("t4_bv_clr", br_valid, 0);
    #1;
    check("t4_idle_crdy", cond_ready, 1);

    // same-cycle flag write and request: stall, then use the new flags
    flag_we    = 1'b1;
    gt_in      = 1'b1;
    cond_valid = 1'b1;
    cond_code  = 3'd4;
    #1;
    check("t5_stall", cond_ready, 0);
    cycle();
    flag_we = 1'b0;
    gt_in   = 1'b0;
    check("t5_flags", flags_out, 3'b100);
    #1;
    check("t5_crdy", cond_ready, 1);
    cycle();
    cond_valid = 1'b0;
    check("t5_bv", br_valid, 1);
    check("t5_bt", br_taken, 1);
    br_ready = 1'b1;
    cycle();
    br_ready = 1'b0;

    // reset while a decision is pending
    cond_valid = 1'b1;
    cond_code  = 3'd6;
    cycle();
    cond_valid = 1'b0;
    check("t6_bv_pre", br_valid, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_bv", br_valid, 0);
    check("t6_flags", flags_out, 0);
    check("t6_bt", br_taken, 0);
    cond_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_stall", cond_ready, 0);
      cycle();
    end
    do_flag(3'b001);
    request(3'd6, 1'b1, "t6_req");

    // randomized traffic against the reference model
    model_flags = 3'b001;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        pat = 3'($urandom_range(0, 7));
        do_flag(pat);
        if ($countones(pat) == 1) model_flags = pat;
        check("rnd_err", flag_err, ($countones(pat) != 1));
        check("rnd_flags", flags_out, model_flags);
      end
      code  = 3'($urandom_range(0, 7));
      exp_t = model_eval(code, model_flags);
      cond_valid = 1'b1;
      cond_code  = code;
      #1;
      check("rnd_crdy", cond_ready, 1);
      cycle();
      cond_valid = 1'b0;
      check("rnd_bv", br_valid, 1);
      check("rnd_bt", br_taken, exp_t);
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 1) == 1) begin
          pat = 3'b001 << $urandom_range(0, 2);
          do_flag(pat);
          model_flags = pat;
          check("rnd_resp_flags", flags_out, model_flags);
        end else begin
          cycle();
        end
        check("rnd_bv_hold", br_valid, 1);
        check("rnd_bt_hold", br_taken, exp_t);
      end
      br_ready = 1'b1;
      cycle();
      br_ready = 1'b0;
      check("rnd_drain", br_valid, 0);
    end

`ifdef BR_STATS_EN
    // saturating statistics: 300 taken decisions, then one not-taken
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("st_rst_t", taken_cnt, 0);
    check("st_rst_n", ntaken_cnt, 0);
    do_flag(3'b001);
    cond_valid = 1'b1;
    cond_code  = 3'd6;
    br_ready   = 1'b1;
    repeat (600) cycle();
    cond_valid = 1'b0;
    cycle();
    br_ready = 1'b0;
    cycle();
    check("st_taken_sat", taken_cnt, 8'hFF);
    check("st_ntaken", ntaken_cnt, 0);
    request(3'd7, 1'b0, "st_never");
    check("st_ntaken_one", ntaken_cnt, 1);
    check("st_taken_hold", taken_cnt, 8'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
